store_merge_unit: RTL and testbench
===================================

# store_merge_unit

Multicycle store sequencer sitting between register B / ALUOut and data memory, the write-direction counterpart of the writeback select path. It turns an `sw`/`sh`/`sb` request into memory traffic: word stores write directly, halfword and byte stores perform a read-modify-write of the containing aligned word, merging the register's low bits into the correct byte lanes. The main control FSM pulses `start` and stalls on `busy` until `done`.

## Interface
- `MEM_LAT`, 1: cycles from the first cycle `mem_addr` is driven with `mem_wr`=0 until `mem_rdata` is valid; must be ≥1.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  request pulse; sampled only in IDLE.
- `size`  in  2  00 word, 01 halfword, 10 byte, 11 reserved.
- `addr`  in  32  byte address (ALUOut).
- `wdata`  in  32  store data (register B); byte uses [7:0], halfword uses [15:0].
- `busy`  out  1  high in every non-IDLE state.
- `done`  out  1  one-cycle completion pulse.
- `align_err`  out  1  one-cycle pulse with `done` on an aborted request.
- `mem_addr`  out  32  word-aligned address `{addr_q[31:2],2'b00}`.
- `mem_wr`  out  1  write strobe, high exactly one cycle per committed store.
- `mem_wdata`  out  32  word to write.
- `mem_rdata`  in  32  memory read data.

## Operation
- States: IDLE, READ, MERGE, WRITE, DONE.
- IDLE: on `start`=1, latch `size`, `addr`, `wdata`. Word goes to WRITE; halfword/byte go to READ; reserved size goes to DONE with `align_err`, no memory access.
- READ: drive `mem_addr`, `mem_wr`=0; counter runs MEM_LAT cycles, then MERGE.
- MERGE: sample `mem_rdata`, register the merged word into `mem_wdata`.
- WRITE: `mem_wr`=1 for one cycle; `mem_addr` unchanged; then DONE.
- DONE: `done`=1 for one cycle; return to IDLE.
- Little-endian lanes. Byte: lane `addr_q[1:0]` takes `wdata[7:0]`. Halfword: `addr_q[1]`=0 → bits [15:0], 1 → bits [31:16]. Untouched lanes keep the read value. Word: `mem_wdata` = `wdata_q`.
- `start` outside IDLE is ignored, not queued. `start` in DONE is also dropped.
- `mem_addr` is stable from the first cycle after `start` through WRITE.
- Reset: all outputs 0, state IDLE. Reset mid-operation aborts with no write and no `done`; a reset coinciding with WRITE still leaves `mem_wr` 0 in the following cycle.

## Timing
- Start accepted at edge 0 (cycle 0 in IDLE).
- Word: WRITE cycle 1, `done` cycle 2; back-to-back `start` earliest cycle 3.
- Partial: READ cycles 1..MEM_LAT, MERGE cycle MEM_LAT+1, WRITE MEM_LAT+2, `done` MEM_LAT+3. MEM_LAT=1: write at cycle 3, `done` cycle 4.
- Abort (reserved or misaligned): `done` + `align_err` cycle 1, no `mem_wr`.
- `busy` deasserts in the cycle after `done`.

## Configuration
- `STORE_ALIGN_CHECK_EN` defined: a halfword with `addr[0]`=1 or a word with `addr[1:0]`≠0 aborts as above, with no memory access.
- Not defined: no alignment check. Word ignores `addr[1:0]`, halfword ignores `addr[0]`, and `align_err` is tied 0 except for reserved size.

## Structure
- Shared package `cpu_store_pkg`: size encodings `SZ_WORD`/`SZ_HALF`/`SZ_BYTE`/`SZ_RSVD`, FSM state enum.
- Sub-module `store_byte_merge`: combinational (old word, data, size, addr[1:0]) → merged word. It is reused by the FSM in MERGE.

## Test plan
- Word store, `addr`=0x10, `wdata`=0xDEADBEEF → `mem_wr` cycle 1 at 0x10 with 0xDEADBEEF, `done` cycle 2, no read phase.
- Byte store, MEM_LAT=1, `addr`=0x22, `wdata`=0x000000AB, memory 0x20 = 0x11223344 → `mem_wr` cycle 3 at 0x20 with 0x11AB3344, `done` cycle 4.
- Halfword store, `addr`=0x42, `wdata`=0xFFFF5A5A, mem = 0x01020304 → writes 0x5A5A0304; repeat with MEM_LAT=3 → `mem_wr` cycle 5.
- With `STORE_ALIGN_CHECK_EN`: word at 0x13 → `done`+`align_err` cycle 1, `mem_wr` never high. Without the macro: writes at 0x10.
- `start` re-pulsed during READ and during DONE → ignored; exactly one `mem_wr` and one `done`.
- `reset` asserted in MERGE → next cycle IDLE, all outputs 0, no `mem_wr`, no `done`; fresh word store afterward completes normally.

Source files
------------

// File: rtl/cpu_store_pkg.sv
// rtl/cpu_store_pkg.sv - shared size encodings, FSM states and alignment helper for the store path
package cpu_store_pkg;

    localparam logic [1:0] SZ_WORD = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_BYTE = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_MERGE,
        ST_WRITE,
        ST_DONE
    } store_state_e;

    function automatic logic store_misaligned(input logic [1:0] size, input logic [1:0] lane);
        logic bad;
        bad = 1'b0;
        case (size)
            SZ_WORD: bad = (lane != 2'b00);
            SZ_HALF: bad = lane[0];
            default: bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/store_byte_merge.sv
// rtl/store_byte_merge.sv - little-endian lane merge of store data into an existing memory word
module store_byte_merge
    import cpu_store_pkg::*;
(
    input  logic [31:0] old_word,
    input  logic [31:0] data,
    input  logic [1:0]  size,
    input  logic [1:0]  lane,
    output logic [31:0] merged
);

    // Halfword placement looks only at lane[1], so an odd halfword address lands on its aligned half
    always_comb begin
        merged = old_word;
        case (size)
            SZ_WORD: merged = data;
            SZ_HALF: begin
                if (lane[1]) merged[31:16] = data[15:0];
                else         merged[15:0]  = data[15:0];
            end
            SZ_BYTE: merged[8*lane +: 8] = data[7:0];
            default: merged = old_word;
        endcase
    end

endmodule

// File: rtl/store_merge_unit.sv
// rtl/store_merge_unit.sv - multicycle sw/sh/sb sequencer with read-modify-write; STORE_ALIGN_CHECK_EN enables misalignment aborts
module store_merge_unit
    import cpu_store_pkg::*;
#(
    parameter int MEM_LAT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  size,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        align_err,
    output logic [31:0] mem_addr,
    output logic        mem_wr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(MEM_LAT - 1);

    store_state_e state_q, state_d;
    logic [1:0]    size_q;
    logic [31:0]   addr_q;
    logic [31:0]   wdata_q;
    logic [31:0]   wdata_out_q;
    logic          err_q;
    logic [CW-1:0] cnt_q;
    logic          abort_req;
    logic [31:0]   merged;

`ifdef STORE_ALIGN_CHECK_EN
    assign abort_req = (size == SZ_RSVD) || store_misaligned(size, addr[1:0]);
`else
    assign abort_req = (size == SZ_RSVD);
`endif

    store_byte_merge u_merge (
        .old_word (mem_rdata),
        .data     (wdata_q),
        .size     (size_q),
        .lane     (addr_q[1:0]),
        .merged   (merged)
    );

    assign mem_addr  = {addr_q[31:2], 2'b00};
    assign mem_wdata = wdata_out_q;

    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        busy      = 1'b1;
        done      = 1'b0;
        mem_wr    = 1'b0;
        align_err = 1'b0;
        case (state_q)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    if (abort_req)             state_d = ST_DONE;
                    else if (size == SZ_WORD)  state_d = ST_WRITE;
                    else                       state_d = ST_READ;
                end
            end
            ST_READ:  if (cnt_q == CNT_LAST) state_d = ST_MERGE;
            ST_MERGE: state_d = ST_WRITE;
            ST_WRITE: begin
                mem_wr  = 1'b1;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                done      = 1'b1;
                align_err = err_q;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Request fields are captured only in IDLE so a stray start later cannot disturb mem_addr
    always_ff @(posedge clk) begin
        if (reset) begin
            size_q      <= SZ_WORD;
            addr_q      <= '0;
            wdata_q     <= '0;
            wdata_out_q <= '0;
            err_q       <= 1'b0;
            cnt_q       <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        size_q  <= size;
                        addr_q  <= addr;
                        wdata_q <= wdata;
                        err_q   <= abort_req;
                        cnt_q   <= '0;
                        if (size == SZ_WORD && !abort_req) wdata_out_q <= wdata;
                    end
                end
                ST_READ:  cnt_q <= cnt_q + 1'b1;
                ST_MERGE: wdata_out_q <= merged;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_store_merge_unit.sv
// tb/tb_store_merge_unit.sv - directed self-checking bench for store_merge_unit at MEM_LAT 1 and 3
module tb_store_merge_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, start, start3;
    logic [1:0]  size;
    logic [31:0] addr, wdata;
    logic        busy1, done1, err1, mwr1;
    logic [31:0] maddr1, mwdata1, mrdata1;
    logic        busy3, done3, err3, mwr3;
    logic [31:0] maddr3, mwdata3, mrdata3;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc1 = 0;
    int cyc3 = 0;

    store_merge_unit #(.MEM_LAT(1)) dut (
        .clk(clk), .reset(reset), .start(start), .size(size), .addr(addr), .wdata(wdata),
        .busy(busy1), .done(done1), .align_err(err1), .mem_addr(maddr1), .mem_wr(mwr1),
        .mem_wdata(mwdata1), .mem_rdata(mrdata1)
    );

    store_merge_unit #(.MEM_LAT(3)) dut3 (
        .clk(clk), .reset(reset), .start(start3), .size(size), .addr(addr), .wdata(wdata),
        .busy(busy3), .done(done3), .align_err(err3), .mem_addr(maddr3), .mem_wr(mwr3),
        .mem_wdata(mwdata3), .mem_rdata(mrdata3)
    );

    function automatic logic [31:0] mem_val(input logic [31:0] a);
        case (a)
            32'h20:  return 32'h11223344;
            32'h40:  return 32'h01020304;
            default: return {16'hC0DE, a[15:0]};
        endcase
    endfunction

    // Read data is only valid MEM_LAT cycles after the read address first appears
    always @(posedge clk) begin
        if (reset) cyc1 <= 0;
        else if (start && !busy1) cyc1 <= 1;
        else if (busy1) cyc1 <= cyc1 + 1;
        if (reset) cyc3 <= 0;
        else if (start3 && !busy3) cyc3 <= 1;
        else if (busy3) cyc3 <= cyc3 + 1;
    end
    assign mrdata1 = (cyc1 >= 2) ? mem_val(maddr1) : 32'hBAD0BAD0;
    assign mrdata3 = (cyc3 >= 4) ? mem_val(maddr3) : 32'hBAD0BAD0;

    int          o_wr_cyc, o_wr_cnt, o_done_cyc, o_done_cnt, o_err_cnt, o_err_with_done;
    int          o_addr_bad, o_busy_after;
    logic [31:0] o_wr_addr, o_wr_data;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input bit use3, input logic [1:0] sz, input logic [31:0] a,
                          input logic [31:0] wd, input int pulse_a, input int pulse_b);
        logic b, d, e, mw;
        logic [31:0] ma, mwd;
        o_wr_cyc = -1; o_wr_cnt = 0; o_done_cyc = -1; o_done_cnt = 0; o_err_cnt = 0;
        o_err_with_done = 0; o_addr_bad = 0; o_busy_after = -1;
        o_wr_addr = '0; o_wr_data = '0;
        size = sz; addr = a; wdata = wd;
        if (use3) start3 = 1'b1; else start = 1'b1;
        for (int c = 1; c <= 14; c++) begin
            step();
            start = 1'b0; start3 = 1'b0;
            if (c == pulse_a || c == pulse_b) begin
                if (use3) start3 = 1'b1; else start = 1'b1;
            end
            b   = use3 ? busy3   : busy1;
            d   = use3 ? done3   : done1;
            e   = use3 ? err3    : err1;
            mw  = use3 ? mwr3    : mwr1;
            ma  = use3 ? maddr3  : maddr1;
            mwd = use3 ? mwdata3 : mwdata1;
            if (o_done_cnt == 1 && c == o_done_cyc + 1) o_busy_after = int'(b);
            if (mw) begin
                o_wr_cnt++;
                if (o_wr_cnt == 1) begin o_wr_cyc = c; o_wr_addr = ma; o_wr_data = mwd; end
            end
            if (d) begin
                o_done_cnt++;
                if (o_done_cnt == 1) o_done_cyc = c;
                if (e) o_err_with_done++;
            end
            if (e) o_err_cnt++;
            if (o_done_cnt == 0 && b && ma !== {a[31:2], 2'b00}) o_addr_bad++;
        end
        start = 1'b0; start3 = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; start3 = 1'b0; size = 2'b00; addr = '0; wdata = '0;
        step(); step();
        n_checks++;
        if ({busy1, done1, err1, mwr1, maddr1, mwdata1} !== 68'd0) begin
            n_fail++; $display("FAIL reset_outputs_lat1: got %h expected 0", {busy1, done1, err1, mwr1, maddr1, mwdata1});
        end
        n_checks++;
        if ({busy3, done3, err3, mwr3, maddr3, mwdata3} !== 68'd0) begin
            n_fail++; $display("FAIL reset_outputs_lat3: got %h expected 0", {busy3, done3, err3, mwr3, maddr3, mwdata3});
        end
        reset = 1'b0;
        step();
    endtask

    task automatic test_word();
        run_op(1'b0, 2'b00, 32'h10, 32'hDEADBEEF, -1, -1);
        n_checks++;
        if (o_wr_cyc !== 1) begin n_fail++; $display("FAIL word_wr_cycle: got %0d expected 1", o_wr_cyc); end
        n_checks++;
        if (o_wr_addr !== 32'h10) begin n_fail++; $display("FAIL word_wr_addr: got %h expected 00000010", o_wr_addr); end
        n_checks++;
        if (o_wr_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL word_wr_data: got %h expected deadbeef", o_wr_data); end
        n_checks++;
        if (o_done_cyc !== 2) begin n_fail++; $display("FAIL word_done_cycle: got %0d expected 2", o_done_cyc); end
        n_checks++;
        if (o_wr_cnt !== 1 || o_done_cnt !== 1 || o_err_cnt !== 0) begin
            n_fail++; $display("FAIL word_counts: got wr=%0d done=%0d err=%0d expected 1 1 0", o_wr_cnt, o_done_cnt, o_err_cnt);
        end
        n_checks++;
        if (o_busy_after !== 0) begin n_fail++; $display("FAIL word_busy_after_done: got %0d expected 0", o_busy_after); end
    endtask

    task automatic test_byte();
        run_op(1'b0, 2'b10, 32'h22, 32'h000000AB, -1, -1);
        n_checks++;
        if (o_wr_cyc !== 3 || o_done_cyc !== 4) begin
            n_fail++; $display("FAIL byte_timing: got wr=%0d done=%0d expected 3 4", o_wr_cyc, o_done_cyc);
        end
        n_checks++;
        if (o_wr_addr !== 32'h20 || o_wr_data !== 32'h11AB3344) begin
            n_fail++; $display("FAIL byte_lane2: got addr=%h data=%h expected 00000020 11ab3344", o_wr_addr, o_wr_data);
        end
        n_checks++;
        if (o_addr_bad !== 0) begin n_fail++; $display("FAIL byte_addr_stable: got %0d unstable cycles expected 0", o_addr_bad); end
        run_op(1'b0, 2'b10, 32'h23, 32'hFFFFFFEE, -1, -1);
        n_checks++;
        if (o_wr_data !== 32'hEE223344) begin n_fail++; $display("FAIL byte_lane3: got %h expected ee223344", o_wr_data); end
        run_op(1'b0, 2'b10, 32'h40, 32'h00000077, -1, -1);
        n_checks++;
        if (o_wr_data !== 32'h01020377) begin n_fail++; $display("FAIL byte_lane0: got %h expected 01020377", o_wr_data); end
    endtask

    task automatic test_half();
        run_op(1'b0, 2'b01, 32'h42, 32'hFFFF5A5A, -1, -1);
        n_checks++;
        if (o_wr_cyc !== 3 || o_wr_data !== 32'h5A5A0304) begin
            n_fail++; $display("FAIL half_lat1: got cyc=%0d data=%h expected 3 5a5a0304", o_wr_cyc, o_wr_data);
        end
        run_op(1'b1, 2'b01, 32'h42, 32'hFFFF5A5A, -1, -1);
        n_checks++;
        if (o_wr_cyc !== 5 || o_done_cyc !== 6 || o_wr_data !== 32'h5A5A0304) begin
            n_fail++; $display("FAIL half_lat3: got wr=%0d done=%0d data=%h expected 5 6 5a5a0304", o_wr_cyc, o_done_cyc, o_wr_data);
        end
        run_op(1'b1, 2'b01, 32'h40, 32'h0000BEEF, -1, -1);
        n_checks++;
        if (o_wr_data !== 32'h0102BEEF || o_wr_addr !== 32'h40) begin
            n_fail++; $display("FAIL half_low_lat3: got addr=%h data=%h expected 00000040 0102beef", o_wr_addr, o_wr_data);
        end
    endtask

    task automatic test_reserved();
        run_op(1'b0, 2'b11, 32'h20, 32'h12345678, -1, -1);
        n_checks++;
        if (o_wr_cnt !== 0 || o_done_cyc !== 1 || o_err_cnt !== 1 || o_err_with_done !== 1) begin
            n_fail++; $display("FAIL reserved_abort: got wr=%0d done_cyc=%0d err=%0d err_with_done=%0d expected 0 1 1 1",
                               o_wr_cnt, o_done_cyc, o_err_cnt, o_err_with_done);
        end
    endtask

    task automatic test_align();
        run_op(1'b0, 2'b00, 32'h13, 32'hDEADBEEF, -1, -1);
`ifdef STORE_ALIGN_CHECK_EN
        n_checks++;
        if (o_wr_cnt !== 0 || o_done_cyc !== 1 || o_err_with_done !== 1) begin
            n_fail++; $display("FAIL align_word_abort: got wr=%0d done_cyc=%0d err=%0d expected 0 1 1", o_wr_cnt, o_done_cyc, o_err_with_done);
        end
`else
        n_checks++;
        if (o_wr_cyc !== 1 || o_wr_addr !== 32'h10 || o_wr_data !== 32'hDEADBEEF || o_err_cnt !== 0) begin
            n_fail++; $display("FAIL align_word_nocheck: got cyc=%0d addr=%h data=%h err=%0d expected 1 00000010 deadbeef 0",
                               o_wr_cyc, o_wr_addr, o_wr_data, o_err_cnt);
        end
`endif
        run_op(1'b0, 2'b01, 32'h43, 32'h00001234, -1, -1);
`ifdef STORE_ALIGN_CHECK_EN
        n_checks++;
        if (o_wr_cnt !== 0 || o_done_cyc !== 1 || o_err_with_done !== 1) begin
            n_fail++; $display("FAIL align_half_abort: got wr=%0d done_cyc=%0d err=%0d expected 0 1 1", o_wr_cnt, o_done_cyc, o_err_with_done);
        end
`else
        n_checks++;
        if (o_wr_cyc !== 3 || o_wr_data !== 32'h12340304 || o_err_cnt !== 0) begin
            n_fail++; $display("FAIL align_half_nocheck: got cyc=%0d data=%h err=%0d expected 3 12340304 0", o_wr_cyc, o_wr_data, o_err_cnt);
        end
`endif
    endtask

    task automatic test_restart_ignored();
        run_op(1'b1, 2'b01, 32'h42, 32'hFFFF5A5A, 2, 6);
        n_checks++;
        if (o_wr_cnt !== 1 || o_done_cnt !== 1 || o_wr_cyc !== 5 || o_wr_data !== 32'h5A5A0304) begin
            n_fail++; $display("FAIL restart_read_done_lat3: got wr=%0d done=%0d cyc=%0d data=%h expected 1 1 5 5a5a0304",
                               o_wr_cnt, o_done_cnt, o_wr_cyc, o_wr_data);
        end
        run_op(1'b0, 2'b10, 32'h22, 32'h000000AB, 1, 4);
        n_checks++;
        if (o_wr_cnt !== 1 || o_done_cnt !== 1 || o_addr_bad !== 0) begin
            n_fail++; $display("FAIL restart_read_done_lat1: got wr=%0d done=%0d addr_bad=%0d expected 1 1 0", o_wr_cnt, o_done_cnt, o_addr_bad);
        end
    endtask

    task automatic test_back_to_back();
        run_op(1'b0, 2'b00, 32'h10, 32'hA5A5A5A5, 2, 3);
        n_checks++;
        if (o_wr_cnt !== 2 || o_done_cnt !== 2) begin
            n_fail++; $display("FAIL back_to_back_counts: got wr=%0d done=%0d expected 2 2", o_wr_cnt, o_done_cnt);
        end
    endtask

    task automatic test_reset_mid();
        int extra;
        size = 2'b10; addr = 32'h22; wdata = 32'h000000AB; start = 1'b1;
        step(); start = 1'b0;
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        n_checks++;
        if ({busy1, done1, err1, mwr1, maddr1, mwdata1} !== 68'd0) begin
            n_fail++; $display("FAIL reset_in_merge_outputs: got %h expected 0", {busy1, done1, err1, mwr1, maddr1, mwdata1});
        end
        extra = 0;
        for (int c = 0; c < 6; c++) begin
            step();
            if (mwr1 || done1) extra++;
        end
        n_checks++;
        if (extra !== 0) begin n_fail++; $display("FAIL reset_in_merge_quiet: got %0d active cycles expected 0", extra); end
        run_op(1'b0, 2'b00, 32'h30, 32'h12345678, -1, -1);
        n_checks++;
        if (o_wr_cyc !== 1 || o_wr_addr !== 32'h30 || o_wr_data !== 32'h12345678 || o_done_cyc !== 2) begin
            n_fail++; $display("FAIL reset_then_word: got cyc=%0d addr=%h data=%h done=%0d expected 1 00000030 12345678 2",
                               o_wr_cyc, o_wr_addr, o_wr_data, o_done_cyc);
        end
        size = 2'b00; addr = 32'h50; wdata = 32'h0BADF00D; start = 1'b1;
        step(); start = 1'b0;
        n_checks++;
        if (mwr1 !== 1'b1) begin n_fail++; $display("FAIL write_state_before_reset: got %b expected 1", mwr1); end
        reset = 1'b1;
        step();
        reset = 1'b0;
        n_checks++;
        if ({mwr1, done1, busy1} !== 3'b000) begin
            n_fail++; $display("FAIL reset_in_write: got %b expected 000", {mwr1, done1, busy1});
        end
        step();
    endtask

    initial begin
        test_reset();
        test_word();
        test_byte();
        test_half();
        test_reserved();
        test_align();
        test_restart_ignored();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
